imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_assembler.sv | 38 +++
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IMEM_DEPTH     = 1024;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned LEN_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_e;

    // Word address base+idx, wrapped to addr_w bits and zero-extended.
    function automatic logic [WORD_W-1:0] wrap_addr(
        input logic [WORD_W-1:0] base,
        input logic [LEN_W-1:0]  idx,
        input int unsigned       addr_w
    );
        logic [WORD_W-1:0] mask;
        mask = (WORD_W'(1) << addr_w) - WORD_W'(1);
        return (base + WORD_W'(idx)) & mask;
    endfunction

endpackage

// File: rtl/imem_loader_assembler.sv
// Packs big-endian bytes into words; word/word_valid are look-ahead
// outputs that already include the byte offered this cycle.
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_c,
    output logic              word_valid_c
);
    localparam int unsigned       CNT_W   = $clog2(BYTES_PER_WORD);
    localparam int unsigned       SHIFT_W = WORD_W - BYTE_W;
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(BYTES_PER_WORD - 1);

    logic [SHIFT_W-1:0] shift_q;
    logic [CNT_W-1:0]   cnt_q;

    assign word_c       = {shift_q, byte_i};
    assign word_valid_c = byte_valid_i && (cnt_q == LAST);

    // Counter wraps to zero after the last byte of a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= word_c[SHIFT_W-1:0];
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer fed by a big-endian byte stream.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = $clog2(IMEM_DEPTH),
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [BYTE_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [LEN_W-1:0]  words_written_o
);
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e FINISH = CHK;
`else
    localparam state_e FINISH = DONE;
`endif

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   len_hi_q;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    words_q, words_d;
    logic                in_ready_q, mem_we_q, busy_q, done_q, error_q;
    logic [WORD_W-1:0]   mem_addr_q, mem_wdata_q;
    logic                accept_c, start_c;
    logic [WORD_W-1:0]   word_c;
    logic                word_valid_c;

    assign accept_c = in_valid_i && in_ready_q;
    assign start_c  = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign len_d    = {len_hi_q, in_data_i};
    assign words_d  = words_q + LEN_W'(1);

    byte_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_c),
        .byte_valid_i ((state_q == DATA) && accept_c),
        .byte_i       (in_data_i),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;

    // Running XOR over data bytes only; length bytes are excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (start_c) begin
            csum_q <= '0;
        end else if ((state_q == DATA) && accept_c) begin
            csum_q <= csum_q ^ in_data_i;
        end
    end
`endif

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start_i) state_d = LEN_HI;
            LEN_HI:          if (accept_c) state_d = LEN_LO;
            LEN_LO: begin
                if (accept_c) begin
                    if (len_d == '0)                  state_d = FINISH;
                    else if (33'(len_d) > MAX_WORDS)  state_d = ERR;
                    else                              state_d = DATA;
                end
            end
            DATA:            if (word_valid_c) state_d = WRITE;
            WRITE:           state_d = (words_d == len_q) ? FINISH : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:             if (accept_c) state_d = (in_data_i == csum_q) ? DONE : ERR;
`endif
            default:         state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid in the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_hi_q    <= '0;
            len_q       <= '0;
            words_q     <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == LEN_HI) || (state_d == LEN_LO) ||
                          (state_d == DATA)   || (state_d == CHK);
            busy_q     <= !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
            done_q     <= (state_d == DONE);
            error_q    <= (state_d == ERR);
            mem_we_q   <= (state_d == WRITE);
            if (start_c) begin
                words_q <= '0;
            end else if (state_q == WRITE) begin
                words_q <= words_d;
            end
            if ((state_q == LEN_HI) && accept_c) len_hi_q <= in_data_i;
            if ((state_q == LEN_LO) && accept_c) len_q    <= len_d;
            if (word_valid_c) begin
                mem_addr_q  <= wrap_addr(WORD_W'(BASE_ADDR), words_q, ADDR_W);
                mem_wdata_q <= word_c;
            end
        end
    end

    assign in_ready_o      = in_ready_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign words_written_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 16) on one stream,
// scored against a byte-level model of the load protocol.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int BASE1 = 16;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int n;
        int stall;
        bit fixed;
        bit send_data;
        bit exp_done;
        bit exp_err;
        int exp_words;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        rdy0, we0, busy0, done0, err0;
    logic [31:0] addr0, wd0;
    logic [15:0] ww0;
    logic        rdy1, we1, busy1, done1, err1;
    logic [31:0] addr1, wd1;
    logic [15:0] ww1;

    int errors = 0;
    int checks = 0;

    logic [7:0]  basic [8] = '{8'h8C, 8'h0A, 8'h00, 8'h20, 8'h11, 8'h4A, 8'h00, 8'h03};

    // Scoreboard state
    int          acc = 0;
    int          n_m = 0;
    int          pk = 0;
    logic [7:0]  nhi = 8'h00;
    logic [7:0]  wb [4];
    logic [31:0] pword = '0;
    bit          pend = 1'b0;
    logic [63:0] log0[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(rdy0), .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wd0),
        .busy_o(busy0), .done_o(done0), .error_o(err0), .words_written_o(ww0)
    );

    imem_loader #(.ADDR_W(10), .BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(rdy1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wd1),
        .busy_o(busy1), .done_o(done1), .error_o(err1), .words_written_o(ww1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the 4th data byte of word k must produce exactly one write,
    // on the next cycle, at (base+k) mod depth with the big-endian word.
    always @(negedge clk) begin
        if (rst) begin
            acc  = 0;
            n_m  = 0;
            pend = 1'b0;
        end else begin
            if (pend || we0 || we1) begin
                chk("we0", 32'(we0), 32'(pend));
                chk("we1", 32'(we1), 32'(pend));
                if (pend) begin
                    chk("addr0", addr0, 32'(pk % DEPTH));
                    chk("addr1", addr1, 32'((BASE1 + pk) % DEPTH));
                    chk("data0", wd0, pword);
                    chk("data1", wd1, pword);
                    chk("ready_in_write", 32'(rdy0), 32'd0);
                end
                pend = 1'b0;
            end
            if (we0) log0.push_back({addr0, wd0});
            if (start && !busy0) begin
                acc = 0;
                log0.delete();
            end else if (in_valid && rdy0) begin
                if (acc == 0) begin
                    nhi = in_data;
                end else if (acc == 1) begin
                    n_m = int'({nhi, in_data});
                end else if (acc < 2 + 4 * n_m) begin
                    wb[(acc - 2) % 4] = in_data;
                    if ((acc - 2) % 4 == 3) begin
                        pend  = 1'b1;
                        pk    = (acc - 2) / 4;
                        pword = {wb[0], wb[1], wb[2], wb[3]};
                    end
                end
                acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic byte_q_t build(input int n, input bit fixed, input bit send_data);
        byte_q_t     q;
        logic [15:0] n16;
        logic [7:0]  b;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0]  x;
        x = 8'h00;
`endif
        n16 = 16'(n);
        q.push_back(n16[15:8]);
        q.push_back(n16[7:0]);
        if (send_data) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = fixed ? basic[i % 8] : 8'($urandom_range(255));
                q.push_back(b);
`ifdef IMEM_LOADER_CHECKSUM_EN
                x ^= b;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            q.push_back(x);
`endif
        end
        return q;
    endfunction

    task automatic stream(input byte_q_t q, input int stall_pct, input int start_at);
        int idx    = 0;
        int budget = 20 * q.size() + 50;
        bit pulsed = 1'b0;
        while (idx < q.size() && budget > 0) begin
            tick();
            budget--;
            start = 1'b0;
            if (start_at >= 0 && idx == start_at && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (int'($urandom_range(99)) < stall_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = q[idx];
            end
            if (in_valid && rdy0) idx++;
        end
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        chk("stream_complete", 32'(idx), 32'(q.size()));
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done0 || err0) && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(rdy0), 0);
        chk({tag, "_we"},    32'(we0),  0);
        chk({tag, "_addr"},  addr0,     0);
        chk({tag, "_wdata"}, wd0,       0);
        chk({tag, "_busy"},  32'(busy0), 0);
        chk({tag, "_done"},  32'(done0), 0);
        chk({tag, "_error"}, 32'(err0),  0);
        chk({tag, "_words"}, 32'(ww0),   0);
        chk({tag, "_busy1"}, 32'(busy1), 0);
    endtask

    vec_t    vecs [8];
    byte_q_t q;
    byte_q_t qpart;

    initial begin
        vecs[0] = '{2,    0,  1'b1, 1'b1, 1'b1, 1'b0, 2};
        vecs[1] = '{2,    50, 1'b1, 1'b1, 1'b1, 1'b0, 2};
        vecs[2] = '{0,    0,  1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[3] = '{1,    30, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[4] = '{7,    20, 1'b0, 1'b1, 1'b1, 1'b0, 7};
        vecs[5] = '{1025, 0,  1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{1024, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1024};
        vecs[7] = '{3,    60, 1'b0, 1'b1, 1'b1, 1'b0, 3};

        #3;
        check_idle_outputs("reset");
        tick();
        tick();
        rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            q = build(vecs[t].n, vecs[t].fixed, vecs[t].send_data);
            do_start();
            chk($sformatf("v%0d_busy_at_start", t), 32'(busy0), 1);
            chk($sformatf("v%0d_done_cleared", t),  32'(done0), 0);
            stream(q, vecs[t].stall, -1);
            wait_end();
            chk($sformatf("v%0d_done", t),   32'(done0), 32'(vecs[t].exp_done));
            chk($sformatf("v%0d_error", t),  32'(err0),  32'(vecs[t].exp_err));
            chk($sformatf("v%0d_words", t),  32'(ww0),   32'(vecs[t].exp_words));
            chk($sformatf("v%0d_writes", t), 32'(log0.size()), 32'(vecs[t].exp_words));
            chk($sformatf("v%0d_done1", t),  32'(done1), 32'(vecs[t].exp_done));
            chk($sformatf("v%0d_busy", t),   32'(busy0), 0);
            chk($sformatf("v%0d_ready", t),  32'(rdy0),  0);
            if (vecs[t].fixed && log0.size() == 2) begin
                chk($sformatf("v%0d_w0", t), log0[0][31:0],  32'h8C0A0020);
                chk($sformatf("v%0d_a1", t), log0[1][63:32], 32'd1);
                chk($sformatf("v%0d_w1", t), log0[1][31:0],  32'h114A0003);
            end
            if (log0.size() > 0)
                chk($sformatf("v%0d_last_addr", t), log0[log0.size() - 1][63:32],
                    32'(vecs[t].exp_words - 1));
        end

        // A stray byte offered after completion must not be taken.
        in_valid = 1'b1;
        in_data  = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_no_accept", 32'(rdy0), 0);
        end
        in_valid = 1'b0;
        chk("done_words_kept", 32'(ww0), 3);

        // start during DATA is ignored; the load completes normally.
        q = build(2, 1'b1, 1'b1);
        do_start();
        stream(q, 0, 4);
        wait_end();
        chk("ign_done",   32'(done0), 1);
        chk("ign_writes", 32'(log0.size()), 2);
        chk("ign_words",  32'(ww0), 2);

        // Restart after done: flags clear immediately, addresses repeat from base.
        do_start();
        chk("restart_done_clear", 32'(done0), 0);
        chk("restart_busy",       32'(busy0), 1);
        chk("restart_words",      32'(ww0),   0);
        stream(q, 10, -1);
        wait_end();
        chk("restart_done", 32'(done0), 1);
        chk("restart_writes", 32'(log0.size()), 2);
        if (log0.size() == 2) chk("restart_a0", log0[0][63:32], 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum: error, but both words stay written.
        q = build(2, 1'b1, 1'b1);
        void'(q.pop_back());
        q.push_back(8'h00);
        do_start();
        stream(q, 0, -1);
        wait_end();
        chk("badsum_error",  32'(err0), 1);
        chk("badsum_done",   32'(done0), 0);
        chk("badsum_writes", 32'(log0.size()), 2);
        chk("badsum_words",  32'(ww0), 2);
`endif

        // Reset after word 3 of 8 aborts at once with no further writes.
        q = build(8, 1'b0, 1'b1);
        qpart = q[0:13];
        do_start();
        stream(qpart, 0, -1);
        tick();
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("midrst_no_more_writes", 32'(log0.size()), 3);
        q = build(1, 1'b0, 1'b1);
        do_start();
        stream(q, 0, -1);
        wait_end();
        chk("after_rst_done",   32'(done0), 1);
        chk("after_rst_writes", 32'(log0.size()), 1);
        if (log0.size() == 1) chk("after_rst_addr", log0[0][63:32], 0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
